id_ex_pipeline_reg: RTL

- ID/EX pipeline register between the decode stage (register file read ports, hazard detection) and the execute stage.
- Captures decoded control, operands and register specifiers each cycle.
- Inserts a bubble when the load-use hazard stall or a branch flush is asserted.
- Applies WB-to-ID same-cycle bypass, because register file writes land on the clock edge while reads are combinational.
- Feeds `ex_rt` and `ex_mem_read` back to the hazard detection logic, and counts stall cycles for performance monitoring.

---
 rtl/id_ex_pipeline_reg.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/id_ex_pipeline_reg.sv
// ID/EX pipeline register: captures decoded instruction fields, applies WB-to-ID
// bypass on both read ports, inserts bubbles on stall/flush/invalid, counts stalls.

module id_ex_bypass #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic [REG_W-1:0]  src_reg,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              wb_reg_write,
  input  logic [REG_W-1:0]  wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic [DATA_W-1:0] op_data
);
  // src_reg is nonzero in the second arm, so a match also excludes wb_write_reg==0
  always_comb begin
    op_data = rf_data;
    if (src_reg == '0)
      op_data = '0;
    else if (wb_reg_write && (wb_write_reg == src_reg))
      op_data = wb_write_data;
  end
endmodule

module id_ex_pipeline_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic [3:0]        id_alu_op,
  input  logic              wb_reg_write,
  input  logic [REG_W-1:0]  wb_write_reg,
  input  logic [DATA_W-1:0] wb_write_data,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_pc,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_write_reg,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic [3:0]        ex_alu_op,
  output logic [CNT_W-1:0]  stall_count
);
  localparam int NUM_PORTS = 2;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  write_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic [3:0]        alu_op;
  } ex_fields_t;

  logic [NUM_PORTS-1:0][REG_W-1:0]  src_reg;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rf_data;
  logic [NUM_PORTS-1:0][DATA_W-1:0] op_data;
  logic       load;
  ex_fields_t ex_d, ex_q;

  assign src_reg = {id_rt, id_rs};
  assign rf_data = {id_rdata2, id_rdata1};

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    id_ex_bypass #(.DATA_W(DATA_W), .REG_W(REG_W)) u_byp (
      .src_reg      (src_reg[p]),
      .rf_data      (rf_data[p]),
      .wb_reg_write (wb_reg_write),
      .wb_write_reg (wb_write_reg),
      .wb_write_data(wb_write_data),
      .op_data      (op_data[p])
    );
  end

  // Anything other than a clean load becomes an all-zero NOP, so mem_read never
  // leaks into the hazard unit from a bubble.
  assign load = id_valid & ~stall & ~flush;

  always_comb begin
    ex_d = '0;
    if (load) begin
      ex_d.valid      = 1'b1;
      ex_d.pc         = id_pc;
      ex_d.rdata1     = op_data[0];
      ex_d.rdata2     = op_data[1];
      ex_d.imm        = id_imm;
      ex_d.rs         = id_rs;
      ex_d.rt         = id_rt;
      ex_d.write_reg  = id_reg_dst ? id_rd : id_rt;
      ex_d.reg_write  = id_reg_write;
      ex_d.mem_read   = id_mem_read;
      ex_d.mem_write  = id_mem_write;
      ex_d.mem_to_reg = id_mem_to_reg;
      ex_d.alu_src    = id_alu_src;
      ex_d.alu_op     = id_alu_op;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) ex_q <= '0;
    else        ex_q <= ex_d;
  end

  // Flush overrides a coincident stall, so only stall-without-flush is counted.
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_count <= '0;
    else if (stall && !flush && (stall_count != {CNT_W{1'b1}}))
      stall_count <= stall_count + 1'b1;
  end

  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_rdata1     = ex_q.rdata1;
  assign ex_rdata2     = ex_q.rdata2;
  assign ex_imm        = ex_q.imm;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_write_reg  = ex_q.write_reg;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_alu_op     = ex_q.alu_op;
endmodule
